dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory of the RISC-V core between two requesters:
  - the core load/store path (CPU);
  - a program/data loader DMA port (DMA).
- Round-robin arbitration, plus a DMA burst lock with a bounded hold time.
- Read data is returned one cycle after grant, tagged to the owning requester.
- Drives a stall to the core whenever its request is not granted.

Parameters:
- ADDR_W, 32, byte address width for both ports and the memory.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MAX_LOCK, 8, maximum consecutive DMA grants under lock before a forced CPU slot. Legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_be  in  DATA_W/8  CPU byte enables
- cpu_gnt  out  1  CPU access accepted this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  CPU load data valid
- cpu_rdata  out  DATA_W  CPU load data
- dma_req, dma_we, dma_addr, dma_wdata, dma_be  in  same widths as the CPU equivalents  DMA request bundle
- dma_lock  in  1  DMA requests back-to-back ownership
- dma_gnt  out  1  DMA access accepted this cycle
- dma_rvalid  out  1  DMA load data valid
- dma_rdata  out  DATA_W  DMA load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables
- mem_rdata  in  DATA_W  valid the cycle after mem_en & ~mem_we

Behaviour:
- Reset (rst low, asynchronous):
  - all outputs 0 except cpu_stall, which is cpu_req (combinational);
  - state = ARB; last_gnt = DMA, so the CPU wins the first tie; lock_cnt = 0.
- Grant logic:
  - Grant is combinational from the requests and registered state.
  - At most one grant per cycle.
  - mem_* is muxed from the granted port; mem_en = cpu_gnt | dma_gnt. With no grant, mem_en = 0 and the other mem_* outputs are 0.
- State ARB:
  - Only one port requesting: that port wins.
  - Both requesting: the port not equal to last_gnt wins.
  - last_gnt updates on every grant.
  - DMA granted with dma_lock = 1: go to LOCK, lock_cnt = 1.
- State LOCK:
  - DMA has priority; dma_gnt = dma_req, and lock_cnt increments on each DMA grant.
  - Leave to ARB when dma_lock = 0 or dma_req = 0; the CPU may be granted in that same cycle under ARB rules.
  - Leave to FORCE when lock_cnt reaches MAX_LOCK and cpu_req = 1.
  - If cpu_req = 0 at MAX_LOCK: stay in LOCK, saturate lock_cnt, keep granting DMA.
- State FORCE:
  - One cycle; CPU granted if cpu_req, DMA not granted.
  - Then go to ARB with last_gnt = CPU and lock_cnt = 0.
  - If cpu_req dropped, FORCE still lasts one cycle with no grant.
- Read return:
  - Registered owner tag and read flag are captured at grant time.
  - The next cycle, owner_rvalid = 1 and owner_rdata = mem_rdata.
  - Non-owner rdata holds its last value; rvalid is 0 otherwise.
  - Writes produce no rvalid.
  - Back-to-back reads from alternating ports return in grant order, one per cycle.
- Request stability: a requester must hold its bundle stable until its gnt. The arbiter does not latch unaccepted requests.
- Reset mid-operation: any pending rvalid is dropped, and the state returns to ARB.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined: adds output cpu_stall_cnt, 32 bits.
  - Increments on every cycle with cpu_stall = 1; saturates at 0xFFFFFFFF.
  - Cleared by reset.
  - Adds input perf_clr, a synchronous clear that has priority over the increment.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Shared package dmem_arb_pkg:
  - state encoding ARB = 2'd0, LOCK = 2'd1, FORCE = 2'd2;
  - owner encoding OWN_CPU = 1'b0, OWN_DMA = 1'b1;
  - default widths.
- Sub-module rr_lock_fsm: state, last_gnt and lock_cnt, producing the grant vector. The top level holds the mux, the return path and the optional counter.

Test Plan:
- Reset, then CPU-only read from 0x10 with memory word 0xDEADBEEF -> cpu_gnt the same cycle; cpu_rvalid = 1 with cpu_rdata = 0xDEADBEEF the next cycle; dma_rvalid = 0.
- Both requesting continuously, no lock -> grants alternate CPU, DMA, CPU, DMA starting with CPU; cpu_stall high on DMA cycles.
- DMA lock burst with MAX_LOCK = 8 and CPU requesting throughout -> 8 consecutive dma_gnt, then one cpu_gnt (FORCE), then alternation resumes.
- DMA lock with cpu_req = 0 for 20 cycles -> 20 consecutive dma_gnt, no FORCE. cpu_req rises in cycle 21 -> CPU granted the next cycle.
- CPU store of 0x12345678 with be = 4'b0011, then DMA read -> mem_we = 1 with mem_be = 0011 in cycle 0; dma_rvalid in cycle 2; no cpu_rvalid.
- rst pulsed low while a read is in flight -> no rvalid after release, state ARB, first tie goes to CPU. With DMEM_ARB_PERF_EN defined, cpu_stall_cnt = 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned ADDR_W_DEF   = 32;
    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned MAX_LOCK_DEF = 8;
    localparam int unsigned CNT_W        = 8;
    localparam int unsigned PERF_W       = 32;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK  = 2'd1,
        FORCE = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    typedef struct packed {
        logic cpu;
        logic dma;
    } gnt_t;

endpackage

// File: rtl/rr_lock_fsm.sv
// Round-robin arbiter with a bounded DMA burst lock.
// Grant vector is combinational from the requests and the registered state.
module rr_lock_fsm
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic dma_req,
    input  logic dma_lock,
    output gnt_t gnt_c
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_LOCK);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    arb_state_e       state, state_n;
    owner_e           last_gnt, last_n;
    logic [CNT_W-1:0] lock_cnt, cnt_n;
    logic             cpu_g, dma_g, use_arb;

    // State, last owner and lock counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ARB;
            last_gnt <= OWN_DMA;
            lock_cnt <= '0;
        end else begin
            state    <= state_n;
            last_gnt <= last_n;
            lock_cnt <= cnt_n;
        end
    end

    // Next state and grant selection.
    always_comb begin
        state_n = state;
        last_n  = last_gnt;
        cnt_n   = lock_cnt;
        cpu_g   = 1'b0;
        dma_g   = 1'b0;
        use_arb = 1'b0;

        case (state)
            ARB: use_arb = 1'b1;
            LOCK: begin
                if (dma_req && dma_lock) begin
                    dma_g  = 1'b1;
                    last_n = OWN_DMA;
                    cnt_n  = (lock_cnt >= MAX_C) ? lock_cnt : lock_cnt + ONE_C;
                    if ((cnt_n >= MAX_C) && cpu_req) begin
                        state_n = FORCE;
                    end
                end else begin
                    use_arb = 1'b1;
                end
            end
            FORCE: begin
                cpu_g   = cpu_req;
                last_n  = OWN_CPU;
                cnt_n   = '0;
                state_n = ARB;
            end
            default: begin
                state_n = ARB;
                cnt_n   = '0;
            end
        endcase

        // Plain round-robin, also used on the cycle a lock is released.
        if (use_arb) begin
            state_n = ARB;
            cnt_n   = '0;
            if (cpu_req && (!dma_req || (last_gnt == OWN_DMA))) begin
                cpu_g  = 1'b1;
                last_n = OWN_CPU;
            end else if (dma_req) begin
                dma_g  = 1'b1;
                last_n = OWN_DMA;
                if (dma_lock) begin
                    cnt_n   = ONE_C;
                    state_n = ((ONE_C >= MAX_C) && cpu_req) ? FORCE : LOCK;
                end
            end
        end

        gnt_c.cpu = cpu_g & rst;
        gnt_c.dma = dma_g & rst;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / DMA) arbiter for the single-port synchronous data memory.
// Optional stall counter enabled by DMEM_ARB_PERF_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
`ifdef DMEM_ARB_PERF_EN
    input  logic                perf_clr,
    output logic [PERF_W-1:0]   cpu_stall_cnt,
`endif
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_be,
    output logic                cpu_gnt,
    output logic                cpu_stall,
    output logic                cpu_rvalid,
    output logic [DATA_W-1:0]   cpu_rdata,
    input  logic                dma_req,
    input  logic                dma_we,
    input  logic [ADDR_W-1:0]   dma_addr,
    input  logic [DATA_W-1:0]   dma_wdata,
    input  logic [DATA_W/8-1:0] dma_be,
    input  logic                dma_lock,
    output logic                dma_gnt,
    output logic                dma_rvalid,
    output logic [DATA_W-1:0]   dma_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata
);

    gnt_t              gnt_c;
    logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;

    rr_lock_fsm #(.MAX_LOCK(MAX_LOCK)) u_fsm (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .dma_req  (dma_req),
        .dma_lock (dma_lock),
        .gnt_c    (gnt_c)
    );

    assign cpu_gnt   = gnt_c.cpu;
    assign dma_gnt   = gnt_c.dma;
    assign cpu_stall = cpu_req & ~gnt_c.cpu;

    // Memory port mux; idle bus is all zeros.
    always_comb begin
        mem_en    = gnt_c.cpu | gnt_c.dma;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (gnt_c.cpu) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_be    = cpu_be;
        end else if (gnt_c.dma) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_be    = dma_be;
        end
    end

    // Read flag tagged with its owner, captured at grant time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= gnt_c.cpu & ~cpu_we;
            dma_rvalid <= gnt_c.dma & ~dma_we;
        end
    end

    // Hold the last returned word for each port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
            if (dma_rvalid) dma_rdata_q <= mem_rdata;
        end
    end

    assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign dma_rdata = dma_rvalid ? mem_rdata : dma_rdata_q;

`ifdef DMEM_ARB_PERF_EN
    // Saturating count of CPU stall cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_stall_cnt <= '0;
        end else if (perf_clr) begin
            cpu_stall_cnt <= '0;
        end else if (cpu_stall && (cpu_stall_cnt != {PERF_W{1'b1}})) begin
            cpu_stall_cnt <= cpu_stall_cnt + PERF_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a small synchronous memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [3:0]  cpu_be, dma_be;
    logic        cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
`ifdef DMEM_ARB_PERF_EN
    logic        perf_clr;
    logic [31:0] cpu_stall_cnt;
`endif

    logic [31:0] mem [0:63];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
`ifdef DMEM_ARB_PERF_EN
        .perf_clr      (perf_clr),
        .cpu_stall_cnt (cpu_stall_cnt),
`endif
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_be     (cpu_be),
        .cpu_gnt    (cpu_gnt),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_be     (dma_be),
        .dma_lock   (dma_lock),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_rdata  (mem_rdata)
    );

    // Synchronous single-port memory: read data valid the cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[7:2]];
        if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_be = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_be = 0;
        dma_lock = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        step();
        step();
        rst = 1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        cpu_req = 1;
        #1;
        vectors++;
        if ({cpu_gnt, dma_gnt, cpu_stall, mem_en} !== 4'b0010) begin
            miscompares++;
            $display("FAIL reset_grants: got %b want 0010", {cpu_gnt, dma_gnt, cpu_stall, mem_en});
        end
        step();
        vectors++;
        if ({cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata} !== 66'd0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %b %b %h %h want 0 0 0 0", cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata);
        end
        cpu_req = 0;
        step();
        rst = 1;
        step();
    endtask

    task automatic test_cpu_read();
        mem[4] = 32'hDEADBEEF;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        #1;
        vectors++;
        if ({cpu_gnt, dma_gnt, cpu_stall, mem_en, mem_we} !== 5'b10010 || mem_addr !== 32'h10) begin
            miscompares++;
            $display("FAIL cpu_read_gnt: got %b addr %h want 10010 addr 10", {cpu_gnt, dma_gnt, cpu_stall, mem_en, mem_we}, mem_addr);
        end
        step();
        cpu_req = 0;
        #1;
        vectors++;
        if ({cpu_rvalid, dma_rvalid} !== 2'b10 || cpu_rdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL cpu_read_data: got %b %h want 10 deadbeef", {cpu_rvalid, dma_rvalid}, cpu_rdata);
        end
        step();
        vectors++;
        if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'hDEADBEEF || mem_en !== 1'b0) begin
            miscompares++;
            $display("FAIL cpu_read_hold: got %b %h en %b want 0 deadbeef en 0", cpu_rvalid, cpu_rdata, mem_en);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        cpu_req = 1; cpu_addr = 32'h20;
        dma_req = 1; dma_addr = 32'h24;
        for (int k = 0; k < 4; k++) begin
            #1;
            vectors++;
            if ({cpu_gnt, dma_gnt, cpu_stall} !== ((k % 2 == 0) ? 3'b100 : 3'b011)) begin
                miscompares++;
                $display("FAIL alt_gnt[%0d]: got %b", k, {cpu_gnt, dma_gnt, cpu_stall});
            end
            if (k > 0) begin
                vectors++;
                if ((k % 2 == 1) ? ({cpu_rvalid, dma_rvalid} !== 2'b10 || cpu_rdata !== 32'hC0DE0008)
                                 : ({cpu_rvalid, dma_rvalid} !== 2'b01 || dma_rdata !== 32'hC0DE0009)) begin
                    miscompares++;
                    $display("FAIL alt_ret[%0d]: got %b %h %h", k, {cpu_rvalid, dma_rvalid}, cpu_rdata, dma_rdata);
                end
            end
            step();
        end
        idle_inputs();
        #1;
        vectors++;
        if ({cpu_rvalid, dma_rvalid} !== 2'b01 || dma_rdata !== 32'hC0DE0009) begin
            miscompares++;
            $display("FAIL alt_last_ret: got %b %h want 01 c0de0009", {cpu_rvalid, dma_rvalid}, dma_rdata);
        end
        step();
    endtask

    task automatic test_lock_force();
        logic [12:0] exp_c;
        logic [12:0] exp_d;
        exp_c = 13'b0101000000001;
        exp_d = 13'b1010111111110;
        do_reset();
        cpu_req = 1; dma_req = 1;
        for (int k = 0; k < 13; k++) begin
            dma_lock = (k < 9);
            #1;
            vectors++;
            if ({cpu_gnt, dma_gnt} !== {exp_c[k], exp_d[k]}) begin
                miscompares++;
                $display("FAIL lock_force[%0d]: got %b want %b", k, {cpu_gnt, dma_gnt}, {exp_c[k], exp_d[k]});
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_lock_no_cpu();
        int dma_cnt;
        dma_cnt = 0;
        do_reset();
        dma_req = 1; dma_lock = 1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (dma_gnt === 1'b1 && cpu_gnt === 1'b0) dma_cnt++;
            step();
        end
        vectors++;
        if (dma_cnt != 20) begin
            miscompares++;
            $display("FAIL lock_idle_cpu: got %0d dma grants want 20", dma_cnt);
        end
        cpu_req = 1;
        #1;
        vectors++;
        if ({cpu_gnt, dma_gnt, cpu_stall} !== 3'b011) begin
            miscompares++;
            $display("FAIL lock_cpu_rise: got %b want 011", {cpu_gnt, dma_gnt, cpu_stall});
        end
        step();
        vectors++;
        if ({cpu_gnt, dma_gnt, cpu_stall} !== 3'b100) begin
            miscompares++;
            $display("FAIL lock_force_cpu: got %b want 100", {cpu_gnt, dma_gnt, cpu_stall});
        end
        idle_inputs();
        step();
    endtask

    task automatic test_store_then_read();
        do_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'h12345678; cpu_be = 4'b0011;
        #1;
        vectors++;
        if ({cpu_gnt, mem_en, mem_we} !== 3'b111 || mem_be !== 4'b0011 || mem_wdata !== 32'h12345678 || mem_addr !== 32'h30) begin
            miscompares++;
            $display("FAIL store_bus: got %b be %b wd %h a %h", {cpu_gnt, mem_en, mem_we}, mem_be, mem_wdata, mem_addr);
        end
        step();
        idle_inputs();
        dma_req = 1; dma_addr = 32'h30;
        #1;
        vectors++;
        if ({dma_gnt, mem_we, cpu_rvalid, dma_rvalid} !== 4'b1000) begin
            miscompares++;
            $display("FAIL store_no_rvalid: got %b want 1000", {dma_gnt, mem_we, cpu_rvalid, dma_rvalid});
        end
        step();
        idle_inputs();
        #1;
        vectors++;
        if ({cpu_rvalid, dma_rvalid} !== 2'b01 || dma_rdata !== 32'hC0DE5678) begin
            miscompares++;
            $display("FAIL store_readback: got %b %h want 01 c0de5678", {cpu_rvalid, dma_rvalid}, dma_rdata);
        end
        step();
    endtask

    task automatic test_reset_midflight();
        cpu_req = 1; cpu_addr = 32'h10;
        #1;
        step();
        cpu_req = 0;
        rst = 0;
        #1;
        vectors++;
        if (cpu_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL midflight_drop: got rvalid %b want 0", cpu_rvalid);
        end
        step();
        rst = 1;
        step();
        vectors++;
        if ({cpu_rvalid, dma_rvalid} !== 2'b00 || cpu_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL midflight_after: got %b %h want 00 0", {cpu_rvalid, dma_rvalid}, cpu_rdata);
        end
`ifdef DMEM_ARB_PERF_EN
        vectors++;
        if (cpu_stall_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL stall_cnt_reset: got %0d want 0", cpu_stall_cnt);
        end
`endif
        cpu_req = 1; dma_req = 1;
        #1;
        vectors++;
        if ({cpu_gnt, dma_gnt} !== 2'b10) begin
            miscompares++;
            $display("FAIL midflight_tie: got %b want 10", {cpu_gnt, dma_gnt});
        end
        idle_inputs();
        step();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = {16'hC0DE, 16'(i)};
        mem_rdata = 32'h0;
`ifdef DMEM_ARB_PERF_EN
        perf_clr = 1'b0;
`endif
        rst = 1'b0;
        idle_inputs();
        #2;
        test_reset();
        test_cpu_read();
        test_alternate();
        test_lock_force();
        test_lock_no_cpu();
        test_store_then_read();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
